// File: rtl/hamming_scrubber_if.sv
// Scrub request/result bundle for hamming_scrubber.
// The requester (master) drives start/data_in/parity_in and receives the corrected
// word, regenerated parity and error statistics. The scrubber is the slave side.
interface hamming_scrubber_if #(
   parameter int WIDTH = 128
);
   localparam int BLOCKS      = WIDTH / 4;
   localparam int PARITY_BITS = BLOCKS * 3;
   localparam int CNT_W       = $clog2(BLOCKS + 1);
   localparam int IDX_W       = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

   logic                   start;
   logic [WIDTH-1:0]       data_in;
   logic [PARITY_BITS-1:0] parity_in;
   logic                   busy;
   logic                   done;
   logic [WIDTH-1:0]       data_out;
   logic [PARITY_BITS-1:0] parity_out;
   logic [CNT_W-1:0]       corr_count;
   logic                   data_err;
   logic [IDX_W-1:0]       first_err_idx;
   logic                   err_valid;

   modport master (
      output start, data_in, parity_in,
      input  busy, done, data_out, parity_out, corr_count, data_err,
             first_err_idx, err_valid
   );

   modport slave (
      input  start, data_in, parity_in,
      output busy, done, data_out, parity_out, corr_count, data_err,
             first_err_idx, err_valid
   );
endinterface

// File: rtl/hamming_scrubber.sv
// Nibble-wise Hamming(7,4) scrubber.
// Captures a word plus its per-nibble parity on an accepted start, then checks and
// corrects BPC blocks per cycle, regenerating clean parity as it goes. A one-cycle
// done pulse marks data_out/parity_out/corr_count/data_err as valid.
// Optional feature: define HAMMING_ERRLOG_EN to latch the lowest block index with a
// nonzero syndrome on first_err_idx/err_valid; otherwise both are tied to zero.
module hamming_scrubber #(
   parameter int WIDTH = 128,
   parameter int BPC   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   hamming_scrubber_if.slave bus
);
   localparam int BLOCKS      = WIDTH / 4;
   localparam int PARITY_BITS = BLOCKS * 3;
   localparam int STEPS       = BLOCKS / BPC;
   localparam int CNT_W       = $clog2(BLOCKS + 1);
   localparam int IDX_W       = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
   localparam int GRP_W       = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [GRP_W-1:0]       grp_q;
   logic                   accept, scan_en, last_grp;

   // The working copy doubles as the result register: it is loaded on accept and
   // corrected in place group by group.
   logic [WIDTH-1:0]       data_q;
   logic [PARITY_BITS-1:0] parity_q;
   logic [CNT_W-1:0]       corr_q;
   logic                   derr_q;

   // Per-group correction results.
   int                     blk_base;
   logic [3:0]             cur_d [BPC];
   logic [2:0]             syn   [BPC];
   logic [3:0]             fix_d [BPC];
   logic [2:0]             fix_p [BPC];
   logic [BPC-1:0]         nz, dflip;
   logic [CNT_W-1:0]       grp_cnt;

   // Parity of one nibble as {p2, p1, p0}.
   function automatic logic [2:0] enc(input logic [3:0] d);
      return {d[0] ^ d[1] ^ d[2], d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3]};
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d  = state_q;
      accept   = 1'b0;
      scan_en  = 1'b0;
      bus.busy = 1'b1;
      bus.done = 1'b0;
      last_grp = (grp_q == GRP_W'(STEPS - 1));
      case (state_q)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               accept  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            scan_en = 1'b1;
            if (last_grp) state_d = DONE;
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Group pointer: walks 0..STEPS-1 while scanning, rewinds on accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     grp_q <= '0;
      else if (accept)  grp_q <= '0;
      else if (scan_en) grp_q <= last_grp ? '0 : grp_q + 1'b1;
   end

   // Syndrome, literal correction map and fresh parity for the current group.
   always_comb begin
      blk_base = int'(grp_q) * BPC;
      nz       = '0;
      dflip    = '0;
      grp_cnt  = '0;
      for (int j = 0; j < BPC; j++) begin
         cur_d[j] = data_q[(blk_base + j) * 4 +: 4];
         syn[j]   = parity_q[(blk_base + j) * 3 +: 3] ^ enc(cur_d[j]);
         fix_d[j] = cur_d[j];
         case (syn[j])
            3'b011:  fix_d[j][3] = ~cur_d[j][3];
            3'b101:  fix_d[j][2] = ~cur_d[j][2];
            3'b110:  fix_d[j][1] = ~cur_d[j][1];
            3'b111:  fix_d[j][0] = ~cur_d[j][0];
            default: ;
         endcase
         fix_p[j] = enc(fix_d[j]);
         nz[j]    = |syn[j];
         dflip[j] = syn[j][0] & syn[j][1] | syn[j][0] & syn[j][2] | syn[j][1] & syn[j][2];
         grp_cnt  = grp_cnt + CNT_W'(nz[j]);
      end
   end

   // Capture on accept, then write back corrected blocks and accumulate statistics.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= '0;
         parity_q <= '0;
         corr_q   <= '0;
         derr_q   <= 1'b0;
      end else if (accept) begin
         data_q   <= bus.data_in;
         parity_q <= bus.parity_in;
         corr_q   <= '0;
         derr_q   <= 1'b0;
      end else if (scan_en) begin
         for (int j = 0; j < BPC; j++) begin
            data_q[(blk_base + j) * 4 +: 4]   <= fix_d[j];
            parity_q[(blk_base + j) * 3 +: 3] <= fix_p[j];
         end
         corr_q <= corr_q + grp_cnt;
         derr_q <= derr_q | (|dflip);
      end
   end

   assign bus.data_out   = data_q;
   assign bus.parity_out = parity_q;
   assign bus.corr_count = corr_q;
   assign bus.data_err   = derr_q;

`ifdef HAMMING_ERRLOG_EN
   logic [IDX_W-1:0] first_q, grp_first;
   logic             ev_q;

   // Lowest flagged block in this group: scanning downward lets the lowest win.
   always_comb begin
      grp_first = '0;
      for (int j = BPC - 1; j >= 0; j--) begin
         if (nz[j]) grp_first = IDX_W'(blk_base + j);
      end
   end

   // Groups arrive in ascending order, so the first latch is the run's lowest index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_q <= '0;
         ev_q    <= 1'b0;
      end else if (accept) begin
         first_q <= '0;
         ev_q    <= 1'b0;
      end else if (scan_en && !ev_q && (|nz)) begin
         first_q <= grp_first;
         ev_q    <= 1'b1;
      end
   end

   assign bus.first_err_idx = first_q;
   assign bus.err_valid     = ev_q;
`else
   assign bus.first_err_idx = '0;
   assign bus.err_valid     = 1'b0;
`endif
endmodule

// File: tb/tb_hamming_scrubber.sv
// Testbench for hamming_scrubber: directed and random words are scrubbed; the
// expected result of each run is queued when the run is issued and a monitor
// compares it against the DUT whenever done is seen.
module tb_hamming_scrubber;
   localparam int W      = 128;
   localparam int BLOCKS = W / 4;
   localparam int PB     = BLOCKS * 3;
   localparam int BPC    = 4;
   localparam int S      = BLOCKS / BPC;
`ifdef HAMMING_ERRLOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]  d;
      logic [PB-1:0] p;
      int            corr;
      bit            derr;
      int            fidx;
      bit            ev;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   prev_done = 1'b0;
   exp_t sb[$];

   always #5 clk = ~clk;

   hamming_scrubber_if #(.WIDTH(W)) bus ();

   hamming_scrubber #(.WIDTH(W), .BPC(BPC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Nibble parity straight from the encoding equations: p0=d0^d2^d3, p1=d0^d1^d3, p2=d0^d1^d2.
   function automatic logic [2:0] nib_par(input logic [3:0] d);
      logic [2:0] p;
      p[0] = d[0] ^ d[2] ^ d[3];
      p[1] = d[0] ^ d[1] ^ d[3];
      p[2] = d[0] ^ d[1] ^ d[2];
      return p;
   endfunction

   function automatic logic [PB-1:0] enc_word(input logic [W-1:0] d);
      logic [PB-1:0] p;
      for (int b = 0; b < BLOCKS; b++) p[b*3 +: 3] = nib_par(d[b*4 +: 4]);
      return p;
   endfunction

   // Reference: each 7-bit block {p,d} with a nonzero syndrome is repaired by the one
   // single-bit flip that makes the syndrome zero (found by search).
   function automatic exp_t model(input logic [W-1:0] d, input logic [PB-1:0] p);
      exp_t       e;
      logic [6:0] cw, t;
      int         hit;
      e.d = d; e.p = p; e.corr = 0; e.derr = 1'b0; e.fidx = 0; e.ev = 1'b0;
      for (int b = 0; b < BLOCKS; b++) begin
         cw = {p[b*3 +: 3], d[b*4 +: 4]};
         if (cw[6:4] != nib_par(cw[3:0])) begin
            hit = -1;
            for (int pos = 0; pos < 7; pos++) begin
               t = cw ^ (7'd1 << pos);
               if (hit < 0 && t[6:4] == nib_par(t[3:0])) hit = pos;
            end
            if (hit >= 0) cw = cw ^ (7'd1 << hit);
            if (hit >= 0 && hit < 4) e.derr = 1'b1;
            e.corr++;
            if (LOG_EN && !e.ev) begin
               e.ev   = 1'b1;
               e.fidx = b;
            end
         end
         e.d[b*4 +: 4] = cw[3:0];
         e.p[b*3 +: 3] = nib_par(cw[3:0]);
      end
      return e;
   endfunction

   task automatic flip(inout logic [W-1:0] d, inout logic [PB-1:0] p, input int b, input int pos);
      if (pos < 4) d[b*4 + pos] = ~d[b*4 + pos];
      else         p[b*3 + pos - 4] = ~p[b*3 + pos - 4];
   endtask

   // Monitor: pop and compare whenever the DUT presents done.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.done === 1'b1) begin
         check("done_one_cycle", W'(prev_done), W'(0));
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done with empty scoreboard expected no done");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("data_out",      bus.data_out,           e.d);
            check("parity_out",    W'(bus.parity_out),     W'(e.p));
            check("corr_count",    W'(bus.corr_count),     W'(e.corr));
            check("data_err",      W'(bus.data_err),       W'(e.derr));
            check("first_err_idx", W'(bus.first_err_idx),  W'(e.fidx));
            check("err_valid",     W'(bus.err_valid),      W'(e.ev));
         end
      end
      prev_done = (reset_n === 1'b1) && (bus.done === 1'b1);
   end

   // One scrub: queue the expectation, start, and time the done pulse.
   task automatic run_scrub(input logic [W-1:0] d, input logic [PB-1:0] p);
      int lat;
      sb.push_back(model(d, p));
      @(negedge clk);
      bus.start     = 1'b1;
      bus.data_in   = d;
      bus.parity_in = p;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_accept", W'(bus.busy), W'(1));
      check("corr_cleared",      W'(bus.corr_count), W'(0));
      while (bus.done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", W'(lat), W'(S + 1));
      @(negedge clk);
      check("busy_dropped", W'(bus.busy), W'(0));
   endtask

   initial begin
      logic [W-1:0]  d;
      logic [PB-1:0] p;
      int            busy_cnt, done_cnt, m, a;

      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.data_in   = '0;
      bus.parity_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",       W'(bus.busy),       W'(0));
      check("rst_done",       W'(bus.done),       W'(0));
      check("rst_data_out",   bus.data_out,       W'(0));
      check("rst_parity_out", W'(bus.parity_out), W'(0));
      check("rst_corr",       W'(bus.corr_count), W'(0));
      check("rst_err_valid",  W'(bus.err_valid),  W'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Clean word.
      d = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
      p = enc_word(d);
      run_scrub(d, p);

      // Single data bit 5 (block 1, d1).
      d[5] = ~d[5];
      run_scrub(d, p);
      d[5] = ~d[5];

      // Single parity bit 94 (block 31).
      p[94] = ~p[94];
      run_scrub(d, p);
      p[94] = ~p[94];

      // d0 flipped in every block.
      for (int b = 0; b < BLOCKS; b++) flip(d, p, b, 0);
      run_scrub(d, p);

      // Random words with zero, one or two flips per block.
      for (int r = 0; r < 10; r++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         p = enc_word(d);
         for (int b = 0; b < BLOCKS; b++) begin
            m = $urandom_range(0, 4);
            a = $urandom_range(0, 6);
            if (m >= 1) flip(d, p, b, a);
            if (m == 4) flip(d, p, b, (a + 1 + $urandom_range(0, 5)) % 7);
         end
         run_scrub(d, p);
      end

      // Starts sampled at edges k+3 and k+8 land in SCAN and must be ignored.
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = enc_word(d);
      flip(d, p, 7, 2);
      sb.push_back(model(d, p));
      @(negedge clk);
      bus.start     = 1'b1;
      bus.data_in   = d;
      bus.parity_in = p;
      @(posedge clk);
      @(negedge clk);
      busy_cnt = bus.busy ? 1 : 0;
      done_cnt = bus.done ? 1 : 0;
      bus.data_in   = ~d;
      bus.parity_in = ~p;
      for (int i = 1; i <= 13; i++) begin
         bus.start = (i == 3 || i == 8);
         @(posedge clk);
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) done_cnt++;
      end
      bus.start = 1'b0;
      check("ignored_start_busy_cycles", W'(busy_cnt), W'(S + 1));
      check("ignored_start_done_pulses", W'(done_cnt), W'(1));

      // Reset dropped mid-scan: everything clears immediately, no done.
      d = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
      p = enc_word(d);
      flip(d, p, 0, 1);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.data_in   = d;
      bus.parity_in = p;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_busy",     W'(bus.busy),       W'(0));
      check("abort_done",     W'(bus.done),       W'(0));
      check("abort_data_out", bus.data_out,       W'(0));
      check("abort_corr",     W'(bus.corr_count), W'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_scrub(d, p);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", W'(sb.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
